// File: rtl/ram_sp_param.sv
// Single-port byte-writable RAM with registered read data, optional extra output
// stage, and an optional zero-fill sequencer that owns the array after reset.
module ram_sp_param #(
    parameter int DW         = 32,
    parameter int DEPTH      = 128,
    parameter int OUT_REG    = 0,
    parameter int CLR_ON_RST = 1,
    localparam int NB        = DW / 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN0,
    input  logic [NB-1:0] WE0,
    input  logic [AW-1:0] A0,
    input  logic [DW-1:0] Di0,
    output logic [DW-1:0] Do0,
    output logic          VLD0,
    output logic          BUSY
);

    // state   | meaning
    // S_CLEAR | sequencer writes zero to ptr each cycle, user accesses ignored
    // S_IDLE  | array owned by the user port
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic          busy_q;
    logic          acc_ok;
    logic          wr_acc;
    logic          rd_acc;
    logic          clr_we;
    logic          s1_vld;
    logic [DW-1:0] s1_dat;
    logic [DW-1:0] mem [DEPTH];

    assign BUSY   = busy_q;
    assign acc_ok = EN0 && !busy_q;
    assign wr_acc = acc_ok && (WE0 != '0);
    assign rd_acc = acc_ok && (WE0 == '0);
    // The array has no reset; gating on RST keeps reset from scribbling address 0.
    assign clr_we = busy_q && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= (CLR_ON_RST != 0) ? S_CLEAR : S_IDLE;
            busy_q <= (CLR_ON_RST != 0);
            ptr    <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem[ptr] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (WE0[i]) begin
                    mem[A0][8*i +: 8] <= Di0[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_dat <= mem[A0];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          s2_vld;
            logic [DW-1:0] s2_dat;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign Do0  = s2_dat;
            assign VLD0 = s2_vld;
        end else begin : g_no_out_reg
            assign Do0  = s1_dat;
            assign VLD0 = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sp_param.sv
// Scoreboard bench: instance a is the default configuration, instance b is a
// 64-bit x 16 array with the extra output register.
module tb_ram_sp_param;

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        a_en, a_vld, a_busy;
    logic [3:0]  a_we;
    logic [6:0]  a_a;
    logic [31:0] a_di, a_do;

    logic        b_en, b_vld, b_busy;
    logic [7:0]  b_we;
    logic [3:0]  b_a;
    logic [63:0] b_di, b_do;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    logic [63:0] ref_b [16];

    ram_sp_param u_a (
        .CLK(CLK), .RST(RST), .EN0(a_en), .WE0(a_we), .A0(a_a), .Di0(a_di),
        .Do0(a_do), .VLD0(a_vld), .BUSY(a_busy)
    );

    ram_sp_param #(.DW(64), .DEPTH(16), .OUT_REG(1), .CLR_ON_RST(1)) u_b (
        .CLK(CLK), .RST(RST), .EN0(b_en), .WE0(b_we), .A0(b_a), .Di0(b_di),
        .Do0(b_do), .VLD0(b_vld), .BUSY(b_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a;
        a_en = 1'b0;
        a_we = '0;
    endtask

    task automatic idle_b;
        b_en = 1'b0;
        b_we = '0;
    endtask

    task automatic wr_a(input int addr, input logic [31:0] data, input logic [3:0] we);
        a_en = 1'b1; a_we = we; a_a = 7'(addr); a_di = data;
        tick;
    endtask

    task automatic rd_a(input int addr, input logic [31:0] data);
        a_en = 1'b1; a_we = '0; a_a = 7'(addr);
        qa.push_back('{d: 64'(data), c: cyc + 1});
        tick;
    endtask

    task automatic wr_b(input int addr, input logic [63:0] data, input logic [7:0] we);
        b_en = 1'b1; b_we = we; b_a = 4'(addr); b_di = data;
        for (int i = 0; i < 8; i++) begin
            if (we[i]) ref_b[addr][8*i +: 8] = data[8*i +: 8];
        end
        tick;
    endtask

    task automatic rd_b(input int addr);
        b_en = 1'b1; b_we = '0; b_a = 4'(addr);
        qb.push_back('{d: ref_b[addr], c: cyc + 2});
        tick;
    endtask

    // Monitor: every VLD0 pulse must match the oldest expectation, in data and cycle.
    always @(negedge CLK) begin
        if (a_vld) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_vld", 64'(a_vld), 64'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_data", 64'(a_do), ea.d);
                chk("a_cycle", 64'(cyc), 64'(ea.c));
            end
        end
        if (b_vld) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_vld", 64'(b_vld), 64'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_data", b_do, eb.d);
                chk("b_cycle", 64'(cyc), 64'(eb.c));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle_a; a_a = '0; a_di = '0;
        idle_b; b_a = '0; b_di = '0;
        for (int i = 0; i < 16; i++) ref_b[i] = '0;
        RST = 1'b1;
        repeat (3) tick;
        chk("rst_busy_a", 64'(a_busy), 64'd1);
        chk("rst_do_a", 64'(a_do), 64'd0);
        chk("rst_vld_a", 64'(a_vld), 64'd0);
        chk("rst_busy_b", 64'(b_busy), 64'd1);

        // Clear phase, hammering the port with writes of all-ones to address 0 and reads.
        RST = 1'b0;
        n = 0;
        while (a_busy && n < 300) begin
            n++;
            a_en = 1'b1; a_a = '0; a_di = '1;
            a_we = n[0] ? 4'hF : 4'h0;
            tick;
        end
        idle_a;
        chk("clear_len_a", 64'(n), 64'd128);
        chk("busy_b_after_clear", 64'(b_busy), 64'd0);

        for (int i = 0; i < 128; i++) rd_a(i, 32'h0);
        idle_a;

        wr_a(5, 32'hAABBCCDD, 4'hF);
        wr_a(5, 32'h11223344, 4'b0101);
        rd_a(5, 32'hAA22CC44);
        idle_a;
        wr_a(127, 32'h12345678, 4'h8);
        wr_a(0, 32'h0000BE00, 4'b0010);
        rd_a(127, 32'h12000000);
        rd_a(0, 32'h0000BE00);
        rd_a(5, 32'hAA22CC44);
        idle_a;
        tick; tick;
        chk("a_hold", 64'(a_do), 64'hAA22CC44);
        chk("a_vld_idle", 64'(a_vld), 64'd0);
        wr_a(5, 32'h0, 4'hF);
        idle_a;
        tick;
        chk("a_hold_after_write", 64'(a_do), 64'hAA22CC44);
        chk("a_vld_after_write", 64'(a_vld), 64'd0);

        // Two-cycle latency, back-to-back reads on b.
        wr_b(1, 64'h0101_0101_0101_0101, 8'hFF);
        wr_b(2, 64'h0202_0202_0202_0202, 8'hFF);
        wr_b(3, 64'h0303_0303_0303_0303, 8'hFF);
        rd_b(1); rd_b(2); rd_b(3);
        idle_b;
        tick; tick;

        for (int i = 0; i < 16; i++) wr_b(i, {$urandom, $urandom}, 8'($urandom));
        for (int i = 0; i < 16; i++) rd_b(i);
        for (int i = 15; i >= 0; i--) wr_b(i, {$urandom, $urandom}, 8'($urandom));
        for (int i = 0; i < 16; i++) rd_b(15 - i);
        idle_b;

        n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 20) begin tick; n++; end
        chk("drain1", 64'(qa.size() + qb.size()), 64'd0);

        // Reset 60 cycles into a clear, with a b read caught in the output pipeline.
        RST = 1'b1; tick; RST = 1'b0;
        for (int i = 0; i < 59; i++) tick;
        b_en = 1'b1; b_we = '0; b_a = 4'd1;
        tick;
        RST = 1'b1;
        idle_b;
        #1;
        chk("midrst_do_a", 64'(a_do), 64'd0);
        chk("midrst_vld_a", 64'(a_vld), 64'd0);
        chk("midrst_busy_a", 64'(a_busy), 64'd1);
        chk("midrst_do_b", b_do, 64'd0);
        chk("midrst_vld_b", 64'(b_vld), 64'd0);
        tick; tick;
        chk("midrst_vld_b2", 64'(b_vld), 64'd0);
        RST = 1'b0;
        n = 0;
        while (a_busy && n < 300) begin n++; tick; end
        chk("clear_len_a2", 64'(n), 64'd128);
        rd_a(5, 32'h0);
        rd_a(127, 32'h0);
        idle_a;

        n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 20) begin tick; n++; end
        chk("drain2", 64'(qa.size() + qb.size()), 64'd0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_sp_param.md
RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 Parameter DW, default 32, data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter DEPTH, default 128, number of words; SHALL be a power of 2, minimum 2.
REQ-003 Parameter OUT_REG, default 0, 0 = read latency 1 cycle, 1 = extra output register, latency 2 cycles.
REQ-004 Parameter CLR_ON_RST, default 1, 1 = hardware zero-fill of the whole array after reset release.
REQ-005 Derived, not overridable: NB = DW/8 byte lanes; AW = log2(DEPTH) address bits.
REQ-006 CLK  input  1  single clock; all state changes on the rising edge.
REQ-007 RST  input  1  reset, asynchronous and active-high.
REQ-008 EN0  input  1  access enable.
REQ-009 WE0  input  NB  per-byte write enable; bit i covers Di0[8i+7:8i].
REQ-010 A0  input  AW  word address.
REQ-011 Di0  input  DW  write data.
REQ-012 Do0  output  DW  read data, registered.
REQ-013 VLD0  output  1  one-cycle pulse marking new valid data on Do0.
REQ-014 BUSY  output  1  high while the clear sequencer owns the array; accesses are ignored.

Function
REQ-015 Access classes, sampled when BUSY=0: EN0=0 -> none; EN0=1 and WE0=0 -> read; EN0=1 and WE0!=0 -> write.
REQ-016 Write: at the sampling edge, only lanes with WE0[i]=1 take Di0; other lanes of word A0 are unchanged.
REQ-017 Write: Do0 is unchanged and VLD0 stays 0; there is no read-through on write.
REQ-018 Read, OUT_REG=0: Do0 = mem[A0] and VLD0=1 in the cycle after the sampling edge.
REQ-019 Read, OUT_REG=1: same, delayed one more cycle; back-to-back reads give one result per cycle, in order.
REQ-020 Do0 holds its last value when there is no new read; VLD0=0 in every cycle without a result.
REQ-021 Read after write to the same address on consecutive cycles returns the newly written data.
REQ-022 Sequencer states: CLEAR and IDLE.
REQ-023 CLEAR: writes all-zero to address ptr and increments ptr each cycle, from 0 to DEPTH-1; BUSY=1.
REQ-024 CLEAR -> IDLE: on the edge that writes DEPTH-1. BUSY falls in the next cycle; the CLEAR phase lasts exactly DEPTH cycles.
REQ-025 In CLEAR, EN0, WE0, A0 and Di0 are ignored: no writes and no VLD0 pulses.
REQ-026 With CLR_ON_RST=0, the sequencer stays in IDLE, BUSY is constant 0, and array contents after reset are undefined.
REQ-027 A read sampled on the final CLEAR cycle is ignored; the first accepted access is on the first cycle with BUSY=0.
REQ-028 The array is a plain register/memory inference usable as a behavioural stand-in for the hard macro; no power pins.

Reset
REQ-029 While RST=1: Do0=0, VLD0=0, and in-flight OUT_REG pipeline data is discarded.
REQ-030 While RST=1: ptr=0; state=CLEAR and BUSY=1 if CLR_ON_RST=1, else state=IDLE and BUSY=0.
REQ-031 RST asserted mid-CLEAR or mid-read aborts the operation; clearing restarts at address 0 after release.
REQ-032 Reset does not alter array contents except through the clear sequence.

Verification
REQ-033 Clear timing: DEPTH=128, CLR_ON_RST=1; release RST -> BUSY=1 for exactly 128 cycles; then reading every address returns 0.
REQ-034 Byte mask: write 0xAABBCCDD to addr 5 with WE0=4'hF, then 0x11223344 with WE0=4'b0101 -> read addr 5 returns 0xAA22CC44, VLD0 one cycle after the read.
REQ-035 Latency: OUT_REG=1; reads of addr 1,2,3 on consecutive cycles -> data appears 2 cycles after each read, VLD0 high for 3 consecutive cycles.
REQ-036 Access during clear: write 0xFFFFFFFF to addr 0 while BUSY=1 -> after clear, addr 0 reads 0 and no VLD0 pulse occurs during BUSY.
REQ-037 Reset mid-clear: assert RST at clear cycle 60, release -> BUSY=1 for a full 128 cycles again; Do0=0 and VLD0=0 during reset.
REQ-038 Params: DW=64, DEPTH=16; write/read all 16 addresses with random data and masks -> every read matches a reference model.
